vec_load_unit: RTL and testbench
================================

// Module: vec_load_unit
// PURPOSE
//  Vector load unit: fetches LANES N-bit elements from data memory (base + lane*STRIDE),
//  assembles them into one vector, and writes it to the vector register file through the
//  we3/ra3/wd3 write port. Sits between the control path and the vector register file, on
//  the write side of that file.
//  One request at a time; the memory read interface is a single-outstanding request/valid pair.
// PARAMETERS
//  N       20  element (lane) width in bits
//  LANES   8   elements per vector; must be 8 to match the register-file write port
//  AW      32  memory address width
//  STRIDE  1   address increment between consecutive lanes
// PORTS
//  clk        in   1          clock; all state updates on posedge
//  reset      in   1          synchronous, active-high
//  start      in   1          load request, sampled only in IDLE
//  base_addr  in   AW         address of lane 0, captured with start
//  dst_reg    in   4          destination vector register, captured with start
//  busy       out  1          high in every state except IDLE
//  done       out  1          one-cycle pulse, coincident with we3
//  mem_rd_en  out  1          one-cycle memory read strobe
//  mem_addr   out  AW         read address, valid while mem_rd_en=1
//  mem_rdata  in   N          read data, valid when mem_rvalid=1
//  mem_rvalid in   1          read data valid
//  we3        out  1          register-file write enable, one-cycle pulse
//  ra3        out  4          register-file write address
//  wd3        out  [7:0][N-1:0]  register-file write data; lane i = element i
// BEHAVIOUR
//  - All outputs are registered. On reset: state=IDLE; busy, done, mem_rd_en and we3 are 0;
//    mem_addr, ra3, wd3 and the lane counter are 0.
//  - FSM states: IDLE, ISSUE, WAIT, WRITE.
//  - IDLE:
//    - start=1 latches base_addr/dst_reg, sets lane=0 -> ISSUE.
//    - start=0 stays IDLE.
//  - ISSUE:
//    - mem_rd_en=1 for exactly this cycle; mem_addr = base + lane*STRIDE mod 2^AW (wraps, no error).
//    - -> WAIT.
//  - WAIT:
//    - mem_rvalid is sampled from the first WAIT cycle on; memory latency >= 1 cycle.
//    - While mem_rvalid=0, stay in WAIT indefinitely; no timeout.
//    - On mem_rvalid=1, write mem_rdata into wd3[lane].
//    - If lane==LANES-1 -> WRITE; else lane+1 -> ISSUE.
//  - WRITE:
//    - we3=1, done=1, ra3=dst_reg for exactly one cycle -> IDLE.
//    - Outputs are driven from posedge, so the negedge-clocked register file samples mid-cycle
//      with stable data.
//  - wd3 and ra3 hold their last values after WRITE until overwritten by the next load.
//    Lanes are overwritten in place during a load; wd3 is meaningful only while we3=1.
//  - start while busy=1: ignored. No queueing; the requester must wait for done.
//  - mem_rvalid outside WAIT: ignored; the data is discarded.
//  - Back-to-back loads: start may be asserted in the cycle after done (state is IDLE then).
//  - Reset mid-operation (any state): return to IDLE at the next edge.
//    No we3 pulse for the aborted load; wd3 clears to 0.
//  - Latency with 1-cycle memory (rvalid in first WAIT cycle): start sampled at edge 0
//    -> we3/done high in cycle 17 (2 cycles per lane + 1). Each extra memory wait cycle adds 1.
// TESTING
//  1. Reset: hold reset 2 cycles -> busy=0, we3=0, mem_rd_en=0, wd3=0.
//  2. Basic load: 1-cycle memory, mem[k]=k+0x100, start with base=0x10, dst=5
//     -> addresses 0x10..0x17 in order; we3 pulses once at cycle 17 with ra3=5,
//     wd3[i]=0x110+i, done coincident.
//  3. Variable latency: memory inserts 0..3 random wait cycles per lane
//     -> same wd3 as test 2; latency = 17 + total waits; exactly one mem_rd_en per lane.
//  4. Start while busy: pulse start with dst=9 during lane 3 -> ignored; the write still goes to
//     ra3=5; a spurious mem_rvalid in ISSUE does not corrupt any lane.
//  5. Address wrap: AW=8, base=0xFE, STRIDE=1 -> addresses FE,FF,00..05.
//  6. Reset mid-load: assert reset in WAIT of lane 4 -> no we3 pulse, IDLE next cycle;
//     a following load to dst=2 completes correctly.

Source files
------------

// File: rtl/vec_load_unit.sv
// Vector load unit: gathers LANES elements from data memory at base + lane*STRIDE, one read at a
// time, and writes the assembled vector to the vector register file through we3/ra3/wd3.
module vec_load_unit #(
  parameter int N      = 20,
  parameter int LANES  = 8,
  parameter int AW     = 32,
  parameter int STRIDE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [AW-1:0]             base_addr,
  input  logic [3:0]                dst_reg,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_rd_en,
  output logic [AW-1:0]             mem_addr,
  input  logic [N-1:0]              mem_rdata,
  input  logic                      mem_rvalid,
  output logic                      we3,
  output logic [3:0]                ra3,
  output logic [LANES-1:0][N-1:0]   wd3
);

  localparam int            LW       = $clog2(LANES);
  localparam logic [AW-1:0] STRIDE_A = AW'(STRIDE);
  localparam logic [LW-1:0] LAST     = LW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t                    state, state_next;
  logic [LW-1:0]             lane, lane_next;
  logic [AW-1:0]             base_q, base_next;
  logic [3:0]                dst_q, dst_next;
  logic [LANES-1:0][N-1:0]   wd3_next;
  logic [AW-1:0]             lane_addr;
  logic                      last_lane;

  assign last_lane = (lane == LAST);

  // Address of the lane about to be issued; wraps modulo 2^AW by construction.
  assign lane_addr = base_next + AW'(lane_next) * STRIDE_A;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    lane_next  = lane;
    base_next  = base_q;
    dst_next   = dst_q;
    wd3_next   = wd3;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          base_next  = base_addr;
          dst_next   = dst_reg;
          lane_next  = '0;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          wd3_next[lane] = mem_rdata;
          if (last_lane) begin
            state_next = S_WRITE;
          end else begin
            lane_next  = lane + LW'(1);
            state_next = S_ISSUE;
          end
        end
      end
      S_WRITE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode, so each strobe is high exactly
  // during the cycle its state is occupied and is stable for the negedge register file.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lane      <= '0;
      base_q    <= '0;
      dst_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      we3       <= 1'b0;
      ra3       <= '0;
      // NOTE: the lane data register is reset too, so an aborted load leaves no stale lanes.
      wd3       <= '0;
    end else begin
      state     <= state_next;
      lane      <= lane_next;
      base_q    <= base_next;
      dst_q     <= dst_next;
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_WRITE);
      we3       <= (state_next == S_WRITE);
      mem_rd_en <= (state_next == S_ISSUE);
      wd3       <= wd3_next;
      if (state_next == S_ISSUE) begin
        mem_addr <= lane_addr;
      end
      if (state_next == S_WRITE) begin
        ra3 <= dst_next;
      end
    end
  end

endmodule

// File: tb/tb_vec_load_unit.sv
// Self-checking bench for vec_load_unit: memory models with optional random wait states and a
// scoreboard of expected read addresses and register-file writes.
module tb_vec_load_unit;

  localparam int N     = 20;
  localparam int LANES = 8;
  localparam int AW    = 32;

  typedef logic [LANES-1:0][N-1:0] vec_t;
  typedef struct {
    logic [3:0] ra;
    vec_t       wd;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main instance (AW=32)
  logic           start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [3:0]     dst_reg = '0;
  logic           busy, done, mem_rd_en, we3;
  logic [AW-1:0]  mem_addr;
  logic [N-1:0]   mem_rdata;
  logic [N-1:0]   model_rdata = '0;
  logic [N-1:0]   spur_data = '0;
  logic           mem_rvalid;
  logic           model_rvalid = 1'b0;
  logic           spur_valid = 1'b0;
  logic [3:0]     ra3;
  vec_t           wd3;

  assign mem_rvalid = model_rvalid | spur_valid;
  assign mem_rdata  = spur_valid ? spur_data : model_rdata;

  vec_load_unit #(.N(N), .LANES(LANES), .AW(AW), .STRIDE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .dst_reg(dst_reg),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .we3(we3), .ra3(ra3), .wd3(wd3)
  );

  // Narrow-address instance for the wrap test
  logic           start8 = 1'b0;
  logic [7:0]     base8 = '0;
  logic [3:0]     dst8 = '0;
  logic           busy8, done8, rd_en8, we3_8;
  logic [7:0]     addr8;
  logic [N-1:0]   rdata8 = '0;
  logic           rvalid8 = 1'b0;
  logic [3:0]     ra3_8;
  vec_t           wd3_8;

  vec_load_unit #(.N(N), .LANES(LANES), .AW(8), .STRIDE(1)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .base_addr(base8), .dst_reg(dst8),
    .busy(busy8), .done(done8), .mem_rd_en(rd_en8), .mem_addr(addr8),
    .mem_rdata(rdata8), .mem_rvalid(rvalid8), .we3(we3_8), .ra3(ra3_8), .wd3(wd3_8)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int load_waits = 0;
  logic extra_wait = 1'b0;
  vec_t last_exp = '0;

  logic [AW-1:0] exp_addr[$];
  wr_t           exp_wr[$];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] mem_val(input logic [AW-1:0] a);
    return N'(a + 32'h100);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model for the main instance: 0..3 extra wait cycles per read when extra_wait is set.
  logic          pend = 1'b0;
  int            pend_cnt = 0;
  logic [AW-1:0] pend_addr = '0;
  always @(posedge clk) begin
    int w;
    model_rvalid <= 1'b0;
    if (reset) begin
      pend <= 1'b0;
    end else if (mem_rd_en) begin
      w = extra_wait ? int'($urandom_range(0, 3)) : 0;
      load_waits <= load_waits + w;
      if (w == 0) begin
        model_rvalid <= 1'b1;
        model_rdata  <= mem_val(mem_addr);
      end else begin
        pend      <= 1'b1;
        pend_cnt  <= w;
        pend_addr <= mem_addr;
      end
    end else if (pend) begin
      if (pend_cnt == 1) begin
        pend         <= 1'b0;
        model_rvalid <= 1'b1;
        model_rdata  <= mem_val(pend_addr);
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  // Zero-wait memory for the narrow instance
  always @(posedge clk) begin
    rvalid8 <= 1'b0;
    if (!reset && rd_en8) begin
      rvalid8 <= 1'b1;
      rdata8  <= mem_val({24'h0, addr8});
    end
  end

  // Scoreboard monitor for the main instance
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (mem_rd_en) begin
        if (exp_addr.size() == 0) check("unexpected_rd_en", mem_rd_en, 1'b0);
        else check("mem_addr", mem_addr, exp_addr.pop_front());
      end
      if (done && !we3) check("we3_with_done", we3, 1'b1);
      if (we3) begin
        check("done_with_we3", done, 1'b1);
        if (exp_wr.size() == 0) begin
          check("unexpected_we3", we3, 1'b0);
        end else begin
          e = exp_wr.pop_front();
          check("ra3", ra3, e.ra);
          check("wd3", wd3, e.wd);
          check("reads_left_at_write", exp_addr.size(), 0);
          check("latency", cyc - start_cyc + 1, 17 + load_waits);
        end
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic launch(input logic [AW-1:0] b, input logic [3:0] d);
    wr_t e;
    for (int i = 0; i < LANES; i++) begin
      exp_addr.push_back(b + AW'(i));
      e.wd[i] = mem_val(b + AW'(i));
    end
    e.ra = d;
    exp_wr.push_back(e);
    last_exp   = e.wd;
    load_waits = 0;
    start_cyc  = cyc + 1;
    start      = 1'b1;
    base_addr  = b;
    dst_reg    = d;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 32'hDEAD_BEEF;
    dst_reg   = 4'hF;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_write(input int budget);
    int k = 0;
    while (!we3 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!we3) check("write_timeout", we3, 1'b1);
    @(negedge clk);
    check("busy_after_write", busy, 1'b0);
    check("we3_single_cycle", we3, 1'b0);
  endtask

  task automatic wait_issue(input logic [AW-1:0] a, input int budget);
    int k = 0;
    while (!(mem_rd_en && mem_addr == a) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(mem_rd_en && mem_addr == a)) check("issue_timeout", mem_rd_en, 1'b1);
  endtask

  initial begin
    logic [7:0] a8;
    vec_t       v8;
    int         k8;

    // 1. Reset held two cycles
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_we3", we3, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rd_en", mem_rd_en, 1'b0);
    check("reset_mem_addr", mem_addr, '0);
    check("reset_ra3", ra3, '0);
    check("reset_wd3", wd3, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 2. Basic load, 1-cycle memory
    extra_wait = 1'b0;
    launch(32'h10, 4'd5);
    wait_write(40);
    repeat (3) @(negedge clk);
    check("wd3_hold", wd3, last_exp);
    check("ra3_hold", ra3, 4'd5);
    spur_valid = 1'b1;
    spur_data  = 20'hBAD00;
    @(negedge clk);
    spur_valid = 1'b0;
    check("idle_rvalid_ignored", wd3, last_exp);

    // 3. Random wait states, back-to-back loads
    extra_wait = 1'b1;
    launch(32'h10, 4'd5);
    wait_write(80);
    launch(32'h30, 4'd11);
    wait_write(80);
    extra_wait = 1'b0;

    // 4. Start while busy and a spurious rvalid during ISSUE of lane 3
    launch(32'h10, 4'd5);
    wait_issue(32'h13, 40);
    start      = 1'b1;
    base_addr  = 32'h80;
    dst_reg    = 4'd9;
    spur_valid = 1'b1;
    spur_data  = 20'hBAD11;
    @(negedge clk);
    spur_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_write(40);

    // 5. Address wrap on the 8-bit instance
    a8 = 8'hFE;
    for (int i = 0; i < LANES; i++) v8[i] = mem_val({24'h0, 8'(a8 + 8'(i))});
    start8 = 1'b1;
    base8  = a8;
    dst8   = 4'd3;
    @(negedge clk);
    start8 = 1'b0;
    k8 = 0;
    for (int c = 0; c < 60 && !we3_8; c++) begin
      if (rd_en8) begin
        check("wrap_addr", addr8, 8'(a8 + 8'(k8)));
        k8++;
      end
      @(negedge clk);
    end
    check("wrap_we3", we3_8, 1'b1);
    check("wrap_done", done8, 1'b1);
    check("wrap_reads", k8, LANES);
    check("wrap_ra3", ra3_8, 4'd3);
    check("wrap_wd3", wd3_8, v8);
    @(negedge clk);
    check("wrap_busy_after", busy8, 1'b0);

    // 6. Reset in the WAIT cycle of lane 4, then a clean load to dst 2
    launch(32'h40, 4'd7);
    wait_issue(32'h44, 40);
    @(negedge clk);
    reset = 1'b1;
    exp_addr.delete();
    exp_wr.delete();
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_we3", we3, 1'b0);
    check("abort_rd_en", mem_rd_en, 1'b0);
    check("abort_wd3", wd3, '0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_idle", busy, 1'b0);
    launch(32'h20, 4'd2);
    wait_write(40);

    repeat (2) @(negedge clk);
    check("queues_drained", exp_addr.size() + exp_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
